// File: rtl/merged_stream_splitter_pkg.sv
// Shared constants for the merged instruction/write-data link.
// Used by the splitter here and by the merge side and command decoder.
package merged_stream_splitter_pkg;

    localparam int unsigned INSTR_WIDTH  = 128;
    localparam int unsigned WDATA_WIDTH  = 512;
    localparam int unsigned MERGED_WIDTH = INSTR_WIDTH + WDATA_WIDTH;

    localparam int unsigned CMD_WIDTH   = 3;
    localparam int unsigned SLOT_STRIDE = 32;
    localparam int unsigned SLOT_COUNT  = 4;

    localparam logic [CMD_WIDTH-1:0] CMD_WR = 3'd4;

    // True when any command slot of the instruction word is a WR.
    function automatic logic has_wr_cmd(input logic [INSTR_WIDTH-1:0] instr);
        logic hit;
        hit = 1'b0;
        for (int unsigned s = 0; s < SLOT_COUNT; s++) begin
            if (instr[s*SLOT_STRIDE +: CMD_WIDTH] == CMD_WR) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/merged_stream_splitter_fork_tracker.sv
// axis_fork_tracker: pending flags for the two forked output beats.
// Ports:
//   clk, rst        clock, async active-high reset
//   s_valid         upstream word valid
//   s_has_wr        upstream word carries a WR command
//   instr_ready     instruction consumer ready
//   wdata_ready     write-data consumer ready
//   ready_c         upstream ready (combinational from the M readies)
//   capture_c       upstream handshake this cycle
//   retire_c        held word fully delivered this cycle
//   instr_valid     instruction beat pending (registered)
//   wdata_valid     write-data beat pending (registered)
module axis_fork_tracker (
    input  logic clk,
    input  logic rst,
    input  logic s_valid,
    input  logic s_has_wr,
    input  logic instr_ready,
    input  logic wdata_ready,
    output logic ready_c,
    output logic capture_c,
    output logic retire_c,
    output logic instr_valid,
    output logic wdata_valid
);

    logic instr_pend;
    logic wdata_pend;
    logic instr_hs;
    logic wdata_hs;

    // Handshakes, upstream ready and the retire pulse.
    always_comb begin
        instr_hs  = instr_pend && instr_ready;
        wdata_hs  = wdata_pend && wdata_ready;
        ready_c   = (!instr_pend || instr_hs) && (!wdata_pend || wdata_hs);
        capture_c = s_valid && ready_c;
        // A word retires only on the cycle its last pending beat goes out.
        retire_c  = (instr_pend || wdata_pend) && ready_c;
    end

    // Capture overrides completion: a new word loads fresh flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_pend <= 1'b0;
            wdata_pend <= 1'b0;
        end else if (capture_c) begin
            instr_pend <= 1'b1;
            wdata_pend <= s_has_wr;
        end else begin
            if (instr_hs) instr_pend <= 1'b0;
            if (wdata_hs) wdata_pend <= 1'b0;
        end
    end

    assign instr_valid = instr_pend;
    assign wdata_valid = wdata_pend;

endmodule

// File: rtl/merged_stream_splitter.sv
// Splits the 640-bit merged stream into a 128-bit instruction stream and
// a 512-bit write-data stream (write data only for words carrying WR).
// Ports:
//   clk, rst                   clock, async active-high reset
//   S_AXIS_*                   merged input stream ([127:0] instr, [639:128] wdata)
//   M_AXIS_INSTR_*             instruction output stream
//   M_AXIS_WDATA_*             write-data output stream
//   word_count                 merged words fully retired
//   wr_word_count              retired words that carried a WR command
module merged_stream_splitter
    import merged_stream_splitter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MERGED_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                    S_AXIS_TVALID,
    output logic                    S_AXIS_TREADY,
    output logic [INSTR_WIDTH-1:0]  M_AXIS_INSTR_TDATA,
    output logic                    M_AXIS_INSTR_TVALID,
    input  logic                    M_AXIS_INSTR_TREADY,
    output logic [WDATA_WIDTH-1:0]  M_AXIS_WDATA_TDATA,
    output logic                    M_AXIS_WDATA_TVALID,
    input  logic                    M_AXIS_WDATA_TREADY,
    output logic [31:0]             word_count,
    output logic [31:0]             wr_word_count
);

    logic                   has_wr_c;
    logic                   capture_c;
    logic                   retire_c;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [WDATA_WIDTH-1:0] wdata_q;
    logic                   word_wr_q;
    logic [31:0]            word_cnt_q;
    logic [31:0]            wr_cnt_q;

    assign has_wr_c = has_wr_cmd(S_AXIS_TDATA[INSTR_WIDTH-1:0]);

    axis_fork_tracker u_tracker (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (S_AXIS_TVALID),
        .s_has_wr    (has_wr_c),
        .instr_ready (M_AXIS_INSTR_TREADY),
        .wdata_ready (M_AXIS_WDATA_TREADY),
        .ready_c     (S_AXIS_TREADY),
        .capture_c   (capture_c),
        .retire_c    (retire_c),
        .instr_valid (M_AXIS_INSTR_TVALID),
        .wdata_valid (M_AXIS_WDATA_TVALID)
    );

    // Held word; its WR flag tags the word for the retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q   <= '0;
            wdata_q   <= '0;
            word_wr_q <= 1'b0;
        end else if (capture_c) begin
            instr_q   <= S_AXIS_TDATA[INSTR_WIDTH-1:0];
            wdata_q   <= S_AXIS_TDATA[MERGED_WIDTH-1:INSTR_WIDTH];
            word_wr_q <= has_wr_c;
        end
    end

    // Retire counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q <= '0;
            wr_cnt_q   <= '0;
        end else if (retire_c) begin
            word_cnt_q <= word_cnt_q + 32'd1;
            if (word_wr_q) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign M_AXIS_INSTR_TDATA = instr_q;
    assign M_AXIS_WDATA_TDATA = wdata_q;
    assign word_count         = word_cnt_q;
    assign wr_word_count      = wr_cnt_q;

endmodule

// File: tb/tb_merged_stream_splitter.sv
// Directed bench for merged_stream_splitter: vector table plus hand sequences.
module tb_merged_stream_splitter;
    import merged_stream_splitter_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [MERGED_WIDTH-1:0] s_tdata;
    logic                    s_tvalid;
    logic                    s_tready;
    logic [INSTR_WIDTH-1:0]  i_tdata;
    logic                    i_tvalid;
    logic                    i_tready;
    logic [WDATA_WIDTH-1:0]  w_tdata;
    logic                    w_tvalid;
    logic                    w_tready;
    logic [31:0]             wc;
    logic [31:0]             wwc;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    merged_stream_splitter dut (
        .clk                 (clk),
        .rst                 (rst),
        .S_AXIS_TDATA        (s_tdata),
        .S_AXIS_TVALID       (s_tvalid),
        .S_AXIS_TREADY       (s_tready),
        .M_AXIS_INSTR_TDATA  (i_tdata),
        .M_AXIS_INSTR_TVALID (i_tvalid),
        .M_AXIS_INSTR_TREADY (i_tready),
        .M_AXIS_WDATA_TDATA  (w_tdata),
        .M_AXIS_WDATA_TVALID (w_tvalid),
        .M_AXIS_WDATA_TREADY (w_tready),
        .word_count          (wc),
        .wr_word_count       (wwc)
    );

    // Beats observed on each output.
    logic [INSTR_WIDTH-1:0] got_i[$];
    logic [WDATA_WIDTH-1:0] got_w[$];
    logic [INSTR_WIDTH-1:0] exp_i[$];
    logic [WDATA_WIDTH-1:0] exp_w[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (i_tvalid && i_tready) got_i.push_back(i_tdata);
            if (w_tvalid && w_tready) got_w.push_back(w_tdata);
        end
    end

    task automatic chk(input string name, input logic [MERGED_WIDTH-1:0] act,
                       input logic [MERGED_WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic                   valid;
        logic                   ir;
        logic                   wr;
        logic [INSTR_WIDTH-1:0] instr;
        logic [WDATA_WIDTH-1:0] wdata;
        logic                   e_sready;
        logic                   e_iv;
        logic                   e_wv;
        logic [INSTR_WIDTH-1:0] e_instr;
        logic [WDATA_WIDTH-1:0] e_wdata;
        logic [31:0]            e_wc;
        logic [31:0]            e_wwc;
    } vec_t;

    localparam logic [INSTR_WIDTH-1:0] NW_I = 128'h00000001_00000001_00000001_00000001;
    localparam logic [INSTR_WIDTH-1:0] WR_I = 128'h00000001_00000004_00000001_00000001;
    localparam logic [WDATA_WIDTH-1:0] WD   = {64{8'hA5}};
    localparam logic [WDATA_WIDTH-1:0] ND   = {64{8'h3C}};

    function automatic vec_t mk(input logic v, input logic ir, input logic wr,
                                input logic [INSTR_WIDTH-1:0] ins, input logic [WDATA_WIDTH-1:0] wd,
                                input logic es, input logic eiv, input logic ewv,
                                input logic [INSTR_WIDTH-1:0] ei, input logic [WDATA_WIDTH-1:0] ew,
                                input logic [31:0] ewc, input logic [31:0] ewwc);
        vec_t t;
        t.valid = v; t.ir = ir; t.wr = wr; t.instr = ins; t.wdata = wd;
        t.e_sready = es; t.e_iv = eiv; t.e_wv = ewv; t.e_instr = ei; t.e_wdata = ew;
        t.e_wc = ewc; t.e_wwc = ewwc;
        return t;
    endfunction

    function automatic logic [INSTR_WIDTH-1:0] seq_instr(input int i);
        logic [INSTR_WIDTH-1:0] r;
        for (int s = 0; s < 4; s++) begin
            r[s*32 +: 32] = {29'(i * 4 + s), ((i % 2 == 0) && s == 3) ? 3'd4 : 3'd1};
        end
        return r;
    endfunction

    vec_t vt[13];
    int   stalls;
    int   base_i;

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; i_tready = 1'b1; w_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_sready", MERGED_WIDTH'(s_tready), MERGED_WIDTH'(1'b1));
        chk("rst_ivalid", MERGED_WIDTH'(i_tvalid), '0);
        chk("rst_wvalid", MERGED_WIDTH'(w_tvalid), '0);
        chk("rst_idata",  MERGED_WIDTH'(i_tdata), '0);
        chk("rst_wdata",  MERGED_WIDTH'(w_tdata), '0);
        chk("rst_wc",     MERGED_WIDTH'(wc), '0);
        chk("rst_wwc",    MERGED_WIDTH'(wwc), '0);
        tick;

        // Per-cycle vectors: inputs for the cycle, expected pre-edge outputs.
        vt[0]  = mk(0,1,1, '0,   '0, 1,0,0, '0,   '0, 0,0);
        vt[1]  = mk(1,1,1, NW_I, ND, 1,0,0, '0,   '0, 0,0);
        vt[2]  = mk(0,1,1, '0,   '0, 1,1,0, NW_I, '0, 0,0);
        vt[3]  = mk(0,1,1, '0,   '0, 1,0,0, '0,   '0, 1,0);
        vt[4]  = mk(1,1,1, WR_I, WD, 1,0,0, '0,   '0, 1,0);
        vt[5]  = mk(0,1,1, '0,   '0, 1,1,1, WR_I, WD, 1,0);
        vt[6]  = mk(0,1,1, '0,   '0, 1,0,0, '0,   '0, 2,1);
        vt[7]  = mk(1,0,1, NW_I, ND, 1,0,0, '0,   '0, 2,1);
        vt[8]  = mk(0,0,1, '0,   '0, 0,1,0, NW_I, '0, 2,1);
        vt[9]  = mk(1,0,1, WR_I, WD, 0,1,0, NW_I, '0, 2,1);
        vt[10] = mk(1,1,1, WR_I, WD, 1,1,0, NW_I, '0, 2,1);
        vt[11] = mk(0,1,1, '0,   '0, 1,1,1, WR_I, WD, 3,1);
        vt[12] = mk(0,1,1, '0,   '0, 1,0,0, '0,   '0, 4,2);

        for (int k = 0; k < 13; k++) begin
            s_tvalid = vt[k].valid;
            s_tdata  = {vt[k].wdata, vt[k].instr};
            i_tready = vt[k].ir;
            w_tready = vt[k].wr;
            #1;
            chk($sformatf("v%0d_sready", k), MERGED_WIDTH'(s_tready), MERGED_WIDTH'(vt[k].e_sready));
            chk($sformatf("v%0d_ivalid", k), MERGED_WIDTH'(i_tvalid), MERGED_WIDTH'(vt[k].e_iv));
            chk($sformatf("v%0d_wvalid", k), MERGED_WIDTH'(w_tvalid), MERGED_WIDTH'(vt[k].e_wv));
            if (vt[k].e_iv) chk($sformatf("v%0d_idata", k), MERGED_WIDTH'(i_tdata), MERGED_WIDTH'(vt[k].e_instr));
            if (vt[k].e_wv) chk($sformatf("v%0d_wdata", k), MERGED_WIDTH'(w_tdata), MERGED_WIDTH'(vt[k].e_wdata));
            chk($sformatf("v%0d_wc", k),  MERGED_WIDTH'(wc),  MERGED_WIDTH'(vt[k].e_wc));
            chk($sformatf("v%0d_wwc", k), MERGED_WIDTH'(wwc), MERGED_WIDTH'(vt[k].e_wwc));
            tick;
        end

        // Write-data consumer stalled for 5 cycles.
        got_i.delete(); got_w.delete();
        s_tvalid = 1'b1; s_tdata = {WD, WR_I}; i_tready = 1'b1; w_tready = 1'b0;
        tick;
        s_tvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall%0d_sready", c), MERGED_WIDTH'(s_tready), '0);
            chk($sformatf("stall%0d_wvalid", c), MERGED_WIDTH'(w_tvalid), MERGED_WIDTH'(1'b1));
            tick;
        end
        chk("stall_instr_beats", MERGED_WIDTH'(got_i.size()), MERGED_WIDTH'(1));
        chk("stall_wdata_beats", MERGED_WIDTH'(got_w.size()), '0);
        w_tready = 1'b1;
        #1;
        chk("release_sready", MERGED_WIDTH'(s_tready), MERGED_WIDTH'(1'b1));
        chk("release_wdata", MERGED_WIDTH'(w_tdata), MERGED_WIDTH'(WD));
        tick;
        tick;
        chk("release_instr_beats", MERGED_WIDTH'(got_i.size()), MERGED_WIDTH'(1));
        chk("release_wdata_beats", MERGED_WIDTH'(got_w.size()), MERGED_WIDTH'(1));
        chk("release_wwc", MERGED_WIDTH'(wwc), MERGED_WIDTH'(3));

        // 100 back-to-back words, alternating WR / non-WR.
        got_i.delete(); got_w.delete(); exp_i.delete(); exp_w.delete();
        stalls = 0;
        base_i = int'(wc);
        for (int i = 0; i < 100; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {{16{32'(i)}}, seq_instr(i)};
            exp_i.push_back(seq_instr(i));
            if (i % 2 == 0) exp_w.push_back({16{32'(i)}});
            #1;
            if (!s_tready) stalls++;
            tick;
        end
        s_tvalid = 1'b0;
        repeat (3) tick;
        chk("stream_stalls", MERGED_WIDTH'(stalls), '0);
        chk("stream_instr_beats", MERGED_WIDTH'(got_i.size()), MERGED_WIDTH'(100));
        chk("stream_wdata_beats", MERGED_WIDTH'(got_w.size()), MERGED_WIDTH'(50));
        for (int i = 0; i < 100; i++) begin
            if (i < got_i.size()) chk($sformatf("stream_i%0d", i), MERGED_WIDTH'(got_i[i]), MERGED_WIDTH'(exp_i[i]));
            if (i < 50 && i < got_w.size()) chk($sformatf("stream_w%0d", i), MERGED_WIDTH'(got_w[i]), MERGED_WIDTH'(exp_w[i]));
        end
        chk("stream_wc",  MERGED_WIDTH'(wc),  MERGED_WIDTH'(base_i + 100));
        chk("stream_wwc", MERGED_WIDTH'(wwc), MERGED_WIDTH'(3 + 50));

        // Async reset while write data is pending.
        s_tvalid = 1'b1; s_tdata = {WD, WR_I}; i_tready = 1'b0; w_tready = 1'b0;
        tick;
        s_tvalid = 1'b0;
        #1;
        chk("prerst_wvalid", MERGED_WIDTH'(w_tvalid), MERGED_WIDTH'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("arst_ivalid", MERGED_WIDTH'(i_tvalid), '0);
        chk("arst_wvalid", MERGED_WIDTH'(w_tvalid), '0);
        chk("arst_wc",     MERGED_WIDTH'(wc), '0);
        chk("arst_wwc",    MERGED_WIDTH'(wwc), '0);
        chk("arst_sready", MERGED_WIDTH'(s_tready), MERGED_WIDTH'(1'b1));
        i_tready = 1'b1; w_tready = 1'b1;
        tick;
        rst = 1'b0;
        got_i.delete(); got_w.delete();
        s_tvalid = 1'b1; s_tdata = {ND, NW_I};
        tick;
        s_tvalid = 1'b0;
        #1;
        chk("post_ivalid", MERGED_WIDTH'(i_tvalid), MERGED_WIDTH'(1'b1));
        chk("post_idata",  MERGED_WIDTH'(i_tdata), MERGED_WIDTH'(NW_I));
        chk("post_wvalid", MERGED_WIDTH'(w_tvalid), '0);
        tick;
        chk("post_wc",  MERGED_WIDTH'(wc), MERGED_WIDTH'(1));
        chk("post_wwc", MERGED_WIDTH'(wwc), '0);
        chk("post_beats", MERGED_WIDTH'(got_i.size() * 10 + got_w.size()), MERGED_WIDTH'(10));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
